// File: rtl/serial_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_receiver                                               |
// | Description : 8N1 UART receiver that reassembles 13-byte frames into the    |
// |               102-bit sensor_iterations word with a hold-until-ack output.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module serial_receiver #(
    parameter int CLKS_PER_BIT  = 12,
    parameter int IDLE_GAP_BITS = 20
) (
    input  logic         clk_12MHz,
    input  logic         rst_n,
    input  logic         rx,
    input  logic         parser_ack,
    output logic [101:0] sensor_iterations,
    output logic         data_avl,
    output logic         frame_error,
    output logic         overrun
);

    localparam int TW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_MAX = IDLE_GAP_BITS * CLKS_PER_BIT;
    localparam int GW      = $clog2(GAP_MAX + 1);

    localparam logic [TW-1:0] C_HALF      = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] C_LAST      = TW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] C_GAP_MAX   = GW'(GAP_MAX);
    localparam logic [GW-1:0] C_GAP_LAST  = GW'(GAP_MAX - 1);
    localparam logic [3:0]    C_LAST_BYTE = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk_12MHz or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [1:0]    sync_vld_q;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_sr_q, byte_sr_d;
    logic [95:0]   frame_sr_q, frame_sr_d;
    logic [3:0]    byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [101:0]  sens_q, sens_d;
    logic          avl_q, avl_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          w_fall;

    // rx_prev only takes real line values once the preset synchroniser has
    // flushed, so a line held low across reset release never looks like a start.
    assign w_fall = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk_12MHz or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            sync_vld_q <= 2'b00;
            rx_prev_q  <= 1'b0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            byte_sr_q  <= '0;
            frame_sr_q <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sens_q     <= '0;
            avl_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            rx_prev_q  <= rx_s_q & sync_vld_q[1];
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_sr_q  <= byte_sr_d;
            frame_sr_q <= frame_sr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sens_q     <= sens_d;
            avl_q      <= avl_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        byte_sr_d  = byte_sr_q;
        frame_sr_d = frame_sr_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sens_d     = sens_q;
        avl_d      = avl_q;
        ferr_d     = 1'b0;
        ovr_d      = ovr_q;

        // A completing frame below overrides the acknowledge.
        if (parser_ack) begin
            avl_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_fall) begin
                    state_d   = S_START;
                    timer_d   = '0;
                    gap_cnt_d = '0;
                end else if ((byte_cnt_q != 4'd0) && (gap_cnt_q != C_GAP_MAX)) begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                    if (gap_cnt_q == C_GAP_LAST) begin
                        byte_cnt_d = 4'd0;
                        ferr_d     = 1'b1;
                    end
                end
            end

            S_START: begin
                if (timer_q == C_HALF) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_DATA: begin
                if (timer_q == C_LAST) begin
                    timer_d   = '0;
                    byte_sr_d = {rx_s_q, byte_sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_STOP: begin
                if (timer_q == C_LAST) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                    if (!rx_s_q) begin
                        ferr_d     = 1'b1;
                        byte_cnt_d = 4'd0;
                    end else if (byte_cnt_q == C_LAST_BYTE) begin
                        byte_cnt_d = 4'd0;
                        if (byte_sr_q[7:6] != 2'b00) begin
                            ferr_d = 1'b1;
                        end else begin
                            sens_d = {byte_sr_q[5:0], frame_sr_q};
                            avl_d  = 1'b1;
                            if (avl_q && !parser_ack) begin
                                ovr_d = 1'b1;
                            end
                        end
                    end else begin
                        for (int b = 0; b < 12; b++) begin
                            if (byte_cnt_q == 4'(b)) begin
                                frame_sr_d[8*b +: 8] = byte_sr_q;
                            end
                        end
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sensor_iterations = sens_q;
    assign data_avl          = avl_q;
    assign frame_error       = ferr_q;
    assign overrun           = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_serial_receiver                                            |
// | Description : Frame-level reference model and per-cycle output checker for  |
// |               serial_receiver, with directed and random UART frames.        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_serial_receiver;

    localparam int CPB      = 12;
    localparam int GAP_BITS = 20;

    logic         clk_12MHz  = 1'b0;
    logic         rst_n      = 1'b0;
    logic         rx         = 1'b1;
    logic         parser_ack = 1'b0;
    logic [101:0] sensor_iterations;
    logic         data_avl;
    logic         frame_error;
    logic         overrun;

    serial_receiver #(
        .CLKS_PER_BIT  (CPB),
        .IDLE_GAP_BITS (GAP_BITS)
    ) u_dut (
        .clk_12MHz         (clk_12MHz),
        .rst_n             (rst_n),
        .rx                (rx),
        .parser_ack        (parser_ack),
        .sensor_iterations (sensor_iterations),
        .data_avl          (data_avl),
        .frame_error       (frame_error),
        .overrun           (overrun)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk_12MHz) cyc++;

    // Reference model: what the outputs must be after each frame-level event.
    logic [101:0] exp_data = '0;
    logic         exp_avl  = 1'b0;
    logic         exp_ovr  = 1'b0;
    int           err_exp  = 0;
    int           err_seen = 0;
    int           last_err_cyc = -1;
    int           avl_rise_cyc = -1;
    bit           chk_en   = 1'b0;
    logic         prev_avl = 1'b0;

    task automatic chk(input string nm, input logic [101:0] act, input logic [101:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    always @(posedge clk_12MHz) begin
        #1;
        if (frame_error === 1'b1) begin
            err_seen++;
            last_err_cyc = cyc;
        end
        if (data_avl === 1'b1 && prev_avl !== 1'b1) begin
            avl_rise_cyc = cyc;
        end
        chk("err_with_avl_rise", {101'd0, frame_error & data_avl & ~prev_avl}, 102'd0);
        if (chk_en) begin
            chk("data_avl", {101'd0, data_avl}, {101'd0, exp_avl});
            chk("overrun", {101'd0, overrun}, {101'd0, exp_ovr});
            chk("sensor_iterations", sensor_iterations, exp_data);
        end
        prev_avl = data_avl;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_12MHz);
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_v);
        rx = 1'b1;
    endtask

    // Sends the first nbytes of the frame {pad, v}; byte bad_idx gets a 0 stop bit.
    task automatic send_frame(input logic [101:0] v, input logic [1:0] pad,
                              input int nbytes, input int bad_idx, input int max_gap);
        logic [103:0] w;
        logic [7:0]   b;
        int           t0;
        w = {pad, v};
        for (int i = 0; i < nbytes; i++) begin
            b  = w[8*i +: 8];
            t0 = cyc;
            if (i == 12) begin
                chk_en       = 1'b0;
                avl_rise_cyc = -1;
            end
            send_byte(b, (i != bad_idx));
            if (i == bad_idx) begin
                err_exp++;
                break;
            end
            if (i == 12) begin
                idle(4);
                if (pad != 2'b00) begin
                    err_exp++;
                end else begin
                    if (!exp_avl) begin
                        chk("avl_latency",
                            {101'd0, (avl_rise_cyc >= t0 + 108) && (avl_rise_cyc <= t0 + 124)},
                            102'd1);
                    end else begin
                        exp_ovr = 1'b1;
                    end
                    exp_data = v;
                    exp_avl  = 1'b1;
                end
                chk_en = 1'b1;
            end else if (i < nbytes - 1 && max_gap > 0) begin
                idle($urandom_range(max_gap, 0));
            end
        end
    endtask

    task automatic ack_pulse();
        parser_ack = 1'b1;
        exp_avl    = 1'b0;
        @(negedge clk_12MHz);
        parser_ack = 1'b0;
    endtask

    task automatic chk_errs(input string nm);
        idle(8);
        chk(nm, 102'(err_seen), 102'(err_exp));
    endtask

    initial begin
        logic [101:0] rv;
        logic [127:0] r128;
        int           t_end;

        idle(5);
        rst_n = 1'b1;
        idle(10);
        chk("reset_data", sensor_iterations, 102'd0);
        chk("reset_avl", {101'd0, data_avl}, 102'd0);
        chk("reset_ovr", {101'd0, overrun}, 102'd0);
        chk("reset_ferr", {101'd0, frame_error}, 102'd0);
        chk_en = 1'b1;

        // Back-to-back frame with the reference pattern.
        send_frame(102'h2A_DEADBEEF_01234567_89ABCDEF, 2'b00, 13, -1, 0);
        chk("f1_literal", sensor_iterations, 102'h2A_DEADBEEF_01234567_89ABCDEF);
        chk_errs("f1_no_error");

        // Second frame without acknowledge -> overwrite and sticky overrun.
        send_frame(102'h1, 2'b00, 13, -1, 0);
        chk("f2_literal", sensor_iterations, 102'h1);
        chk("f2_overrun", {101'd0, overrun}, 102'd1);
        ack_pulse();
        chk("ack_clears_avl", {101'd0, data_avl}, 102'd0);
        chk("ack_keeps_ovr", {101'd0, overrun}, 102'd1);

        // Partial frame abandoned by the idle-gap timeout.
        r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_frame(r128[101:0], 2'b00, 5, -1, 30);
        t_end = cyc;
        idle(300);
        err_exp++;
        chk("timeout_err_count", 102'(err_seen), 102'(err_exp));
        chk("timeout_position",
            {101'd0, (last_err_cyc >= t_end + 225) && (last_err_cyc <= t_end + 250)}, 102'd1);
        send_frame(102'h3, 2'b00, 13, -1, 20);
        chk("f3_literal", sensor_iterations, 102'h3);
        chk_errs("f3_no_error");

        // Bad stop bit on byte 4, then a clean retransmission.
        ack_pulse();
        r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
        rv   = r128[101:0];
        send_frame(rv, 2'b00, 13, 4, 0);
        chk_errs("bad_stop_err");
        send_frame(rv, 2'b00, 13, -1, 10);
        chk_errs("retx_no_error");

        // Padding bits set in byte 12 (byte value 8'hC0).
        send_frame(102'h0_00ABCDEF_00000000_12345678, 2'b11, 13, -1, 0);
        chk_errs("padding_err");

        // Short low glitch on an idle line.
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        chk_errs("glitch_no_error");

        // Reset in the middle of byte 7, line held low across release.
        r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_frame(r128[101:0], 2'b00, 7, -1, 0);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        rx       = 1'b0;
        rst_n    = 1'b0;
        exp_data = '0;
        exp_avl  = 1'b0;
        exp_ovr  = 1'b0;
        #1;
        chk("midreset_data", sensor_iterations, 102'd0);
        chk("midreset_avl", {101'd0, data_avl}, 102'd0);
        chk("midreset_ovr", {101'd0, overrun}, 102'd0);
        idle(5);
        rst_n = 1'b1;
        idle(30);
        rx = 1'b1;
        idle(30);
        chk_errs("reset_release_no_error");
        send_frame(102'h15_0F0F0F0F_F0F0F0F0_A5A55A5A, 2'b00, 13, -1, 0);
        chk("post_reset_literal", sensor_iterations, 102'h15_0F0F0F0F_F0F0F0F0_A5A55A5A);

        // Random frames, gaps and acknowledges.
        for (int f = 0; f < 6; f++) begin
            r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(1, 0) == 1) ack_pulse();
            send_frame(r128[101:0], 2'b00, 13, -1, 60);
            idle($urandom_range(20, 0));
        end
        chk_errs("random_no_error");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
